// File: rtl/hb3_sensor_decoder.sv
// Quadrature hall decoder for the Pmod HB3: sync, deglitch, 4x decode, windowed speed.
// Define HB3_POSITION_EN to add the signed 32-bit position accumulator output.
module hb3_sensor_decoder #(
  parameter int FILTER_LEN    = 4,
  parameter int WINDOW_CYCLES = 1000000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sa,
  input  logic             sb,
  output logic [CNT_W-1:0] speed_count,
  output logic             direction,
  output logic             valid,
  output logic             error
`ifdef HB3_POSITION_EN
  ,
  output logic signed [31:0] position
`endif
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int PW = $clog2(FILTER_LEN + 3);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]          s1_q, s2_q;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][FW-1:0]  fc_q, fc_d;
  logic [1:0]          prev_q, prev_d;
  logic                prime_q, prime_d;
  logic [PW-1:0]       pc_q, pc_d;
  logic [WW-1:0]       win_q, win_d;
  logic [CNT_W-1:0]    ecnt_q, ecnt_d, ecnt_nx;
  logic [CNT_W-1:0]    speed_q, speed_d;
  logic                dir_q, dir_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                fwd, rev, ill, tc;
`ifdef HB3_POSITION_EN
  logic signed [31:0]  pos_q, pos_d;
`endif

  always_comb begin
    filt_d = filt_q;
    fc_d   = fc_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (fc_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_d[i] = s2_q[i];
          fc_d[i]   = '0;
        end else begin
          fc_d[i] = fc_q[i] + 1'b1;
        end
      end else begin
        fc_d[i] = '0;
      end
    end
  end

  // {prev, cur} with A as the high bit of each pair
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    ill = 1'b0;
    if (!prime_q) begin
      unique case ({prev_q, filt_q})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
        4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
        4'b0011, 4'b1100, 4'b1001, 4'b0110: ill = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    tc      = (win_q == WW'(WINDOW_CYCLES - 1));
    win_d   = tc ? '0 : win_q + 1'b1;
    ecnt_nx = ecnt_q;
    if ((fwd || rev) && ecnt_q != CNT_MAX)
      ecnt_nx = ecnt_q + 1'b1;
    ecnt_d  = tc ? '0 : ecnt_nx;
    speed_d = tc ? ecnt_nx : speed_q;
    valid_d = tc;
    err_d   = ill;
    dir_d   = fwd ? 1'b1 : (rev ? 1'b0 : dir_q);
    // Track the incoming filtered value while priming so the resting state is never decoded
    prev_d  = prime_q ? filt_d : filt_q;
    prime_d = prime_q;
    pc_d    = pc_q;
    if (prime_q) begin
      if (pc_q == PW'(FILTER_LEN + 1))
        prime_d = 1'b0;
      else
        pc_d = pc_q + 1'b1;
    end
`ifdef HB3_POSITION_EN
    pos_d = pos_q;
    if (fwd) pos_d = pos_q + 32'sd1;
    else if (rev) pos_d = pos_q - 32'sd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      filt_q  <= '0;
      fc_q    <= '0;
      prev_q  <= '0;
      prime_q <= 1'b1;
      pc_q    <= '0;
      win_q   <= '0;
      ecnt_q  <= '0;
      speed_q <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef HB3_POSITION_EN
      pos_q   <= '0;
`endif
    end else begin
      s1_q    <= {sa, sb};
      s2_q    <= s1_q;
      filt_q  <= filt_d;
      fc_q    <= fc_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
      pc_q    <= pc_d;
      win_q   <= win_d;
      ecnt_q  <= ecnt_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef HB3_POSITION_EN
      pos_q   <= pos_d;
`endif
    end
  end

  assign speed_count = speed_q;
  assign direction   = dir_q;
  assign valid       = valid_q;
  assign error       = err_q;
`ifdef HB3_POSITION_EN
  assign position    = pos_q;
`endif

endmodule

// File: tb/tb_hb3_sensor_decoder.sv
// Scoreboard bench for hb3_sensor_decoder: a 16-bit and a saturating 4-bit
// instance share the same sensor stimulus.
module tb_hb3_sensor_decoder;
  localparam int FL  = 4;
  localparam int WIN = 1000;
  localparam int IDLE = 0, FWD = 1, REV = 2, GLITCH = 3, ILL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sa  = 1'b1;
  logic        sb  = 1'b1;
  logic [15:0] speed;
  logic        dir, vld, err;
  logic [3:0]  speed4;
  logic        dir4, vld4, err4;
`ifdef HB3_POSITION_EN
  logic signed [31:0] pos, pos4;
`endif

  always #5 clk = ~clk;

  hb3_sensor_decoder #(.FILTER_LEN(FL), .WINDOW_CYCLES(WIN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sa(sa), .sb(sb),
    .speed_count(speed), .direction(dir), .valid(vld), .error(err)
`ifdef HB3_POSITION_EN
    , .position(pos)
`endif
  );

  hb3_sensor_decoder #(.FILTER_LEN(FL), .WINDOW_CYCLES(WIN), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sa(sa), .sb(sb),
    .speed_count(speed4), .direction(dir4), .valid(vld4), .error(err4)
`ifdef HB3_POSITION_EN
    , .position(pos4)
`endif
  );

  typedef struct {
    int cnt;
    bit dir;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         errors   = 0;
  int         err_seen = 0;
  logic [1:0] ab       = 2'b11;
  int         pos_m    = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00: return 2'b10;
      2'b10: return 2'b11;
      2'b11: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] s);
    case (s)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (err) err_seen++;
    if (vld) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", sbq.size(), 1);
      end else begin
        mon_e = sbq.pop_front();
        check("speed", speed, mon_e.cnt);
        check("dir", dir, mon_e.dir);
        check("speed_sat", speed4, (mon_e.cnt > 15) ? 15 : mon_e.cnt);
        check("valid_sat", vld4, 1);
      end
    end
  end

  task automatic drive_ab();
    sa = ab[1];
    sb = ab[0];
  endtask

  task automatic run_window(input int mode, input int ncnt, input bit ndir,
                            input int nerr);
    exp_t x;
    int   e0;
    int   vpos;
    x.cnt = ncnt;
    x.dir = ndir;
    sbq.push_back(x);
    e0   = err_seen;
    vpos = -1;
    for (int j = 0; j < WIN; j++) begin
      @(posedge clk);
      #1;
      if (vld) vpos = (vpos == -1) ? j : -2;
      if ((mode == FWD || mode == REV) && (j % 50 == 10)) begin
        ab    = (mode == FWD) ? fwd_next(ab) : rev_next(ab);
        pos_m = (mode == FWD) ? pos_m + 1 : pos_m - 1;
        drive_ab();
      end
      if (mode == REV && j == 17) check("dir_latency", dir, 0);
      if (mode == GLITCH && j == 100) sa = ~ab[1];
      if (mode == GLITCH && j == 102) sa = ab[1];
      if (mode == ILL && j == 100) begin
        ab = ~ab;
        drive_ab();
      end
    end
    check("valid_pos", vpos, WIN - 1);
    check("err_pulses", err_seen - e0, nerr);
`ifdef HB3_POSITION_EN
    check("position", pos, pos_m);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {speed, dir, vld, err}, 0);
    check("reset_sat", {speed4, vld4, err4}, 0);
    @(negedge clk);
    rst = 1'b1;

    run_window(IDLE,   0,  1'b0, 0);
    run_window(FWD,    20, 1'b1, 0);
    run_window(FWD,    20, 1'b1, 0);
    run_window(REV,    20, 1'b0, 0);
    run_window(GLITCH, 0,  1'b0, 0);
    run_window(ILL,    0,  1'b0, 1);
    run_window(FWD,    20, 1'b1, 0);

    for (int j = 0; j < 500; j++) begin
      @(posedge clk);
      #1;
      if (j % 50 == 10) begin
        ab    = fwd_next(ab);
        pos_m = pos_m + 1;
        drive_ab();
      end
    end
    #2 rst = 1'b0;
    #1;
    check("async_reset", {speed, dir, vld, err}, 0);
    pos_m = 0;
`ifdef HB3_POSITION_EN
    check("position_reset", pos, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_window(IDLE, 0,  1'b0, 0);
    run_window(FWD,  20, 1'b1, 0);

    repeat (5) @(posedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
